// File: rtl/mips_cpu_test_monitor.sv
// mips_cpu_test_monitor: end-of-program checker (boot/halt/timeout; PC stall when MIPS_MON_STALL_DETECT_EN is defined)
module mips_cpu_test_monitor #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR      = 32'h00000000,
  parameter logic [31:0] EXPECTED_V0    = 32'h00000001,
  parameter int          TIMEOUT_CYCLES = 200,
  parameter int          CNT_W          = 16,
  parameter int          STALL_LIMIT    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             active,
  input  logic [31:0]      instr_address,
  input  logic [31:0]      register_v0,
  output logic             done,
  output logic             pass,
  output logic [2:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count,
  output logic [31:0]      v0_at_halt
);
  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0] state;
  logic [31:0] prev_addr;
  logic [CNT_W-1:0] cycle_inc, fetch_inc;
  logic timeout, changed, v0_ok;
  assign cycle_inc = &cycle_count ? cycle_count : cycle_count + 1'b1;
  assign fetch_inc = &fetch_count ? fetch_count : fetch_count + 1'b1;
  assign timeout   = cycle_count == CNT_W'(TIMEOUT_CYCLES - 1);
  assign changed   = instr_address != prev_addr;
  assign v0_ok     = register_v0 == EXPECTED_V0;
`ifdef MIPS_MON_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [SW-1:0] stall_cnt, stall_next;
  logic stall_hit;
  assign stall_next = changed ? '0 : stall_cnt + 1'b1;
  assign stall_hit  = stall_next == SW'(STALL_LIMIT);
  always_ff @(posedge clk)
    if (reset) stall_cnt <= '0;
    else if (clk_enable && state == S_RUN && instr_address != HALT_ADDR && active) stall_cnt <= stall_next;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BOOT;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= 3'd0;
      cycle_count <= '0;
      fetch_count <= '0;
      v0_at_halt  <= '0;
      prev_addr   <= '0;
    end else if (clk_enable) begin
      case (state)
        S_BOOT:
          if (instr_address == RESET_VECTOR && active) begin
            state       <= S_RUN;
            prev_addr   <= instr_address;
            cycle_count <= cycle_inc;
          end else if (timeout) begin
            state     <= S_DONE;
            done      <= 1'b1;
            fail_code <= 3'd3;
          end else cycle_count <= cycle_inc;
        S_RUN:
          // halt is checked first so it wins over inactivity, stall and timeout
          if (instr_address == HALT_ADDR) begin
            state      <= S_DONE;
            done       <= 1'b1;
            v0_at_halt <= register_v0;
            pass       <= v0_ok;
            fail_code  <= v0_ok ? 3'd0 : 3'd1;
          end else if (!active) begin
            state     <= S_DONE;
            done      <= 1'b1;
            fail_code <= 3'd3;
          end
`ifdef MIPS_MON_STALL_DETECT_EN
          else if (stall_hit) begin
            state     <= S_DONE;
            done      <= 1'b1;
            fail_code <= 3'd4;
          end
`endif
          else if (timeout) begin
            state     <= S_DONE;
            done      <= 1'b1;
            fail_code <= 3'd2;
          end else begin
            cycle_count <= cycle_inc;
            fetch_count <= changed ? fetch_inc : fetch_count;
            prev_addr   <= instr_address;
          end
        default: ;
      endcase
    end
  end
endmodule
